// File: rtl/pc_fetch_ctrl.sv
// +--------------------------------------------------------------------------+
// | pc_fetch_ctrl: single-outstanding instruction fetch controller with      |
// | redirect handling and a one-entry output buffer toward decode.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_fetch_ctrl #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_if_pc;
    logic [31:0]     r_if_instr;
    logic            r_misalign;
    logic            w_capture;
    logic [XLEN-1:0] w_redirect_aligned;

    assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_VECTOR;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (w_capture) begin
                r_if_pc    <= r_pc;
                r_if_instr <= imem_rsp_data;
            end
        end
    end

    // Redirect wins over every other event; it only decides whether a
    // response is still owed by the imem (DROP) or not (REQ).
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_req_ready ? S_DROP : S_REQ;
                end else if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    w_state_nxt = S_REQ;
                end else if (if_ready) begin
                    w_pc_nxt    = r_pc + XLEN'(4);
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (!redirect_valid && imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
        if (redirect_valid) begin
            w_pc_nxt = w_redirect_aligned;
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign if_valid       = (r_state == S_OUT);
    assign if_pc          = r_if_pc;
    assign if_instr       = r_if_instr;
    assign misalign_err   = r_misalign;

endmodule

`default_nettype wire

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  XLEN  32  address/PC width
  RESET_VECTOR  0  first fetch address after reset
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  input  1  single clock; all state updates on rising edge
  rst  input  1  reset, synchronous, active-high
  redirect_valid  input  1  taken branch/jump this cycle
  redirect_pc  input  XLEN  branch/jump target
  imem_req_valid  output  1  fetch request valid
  imem_req_ready  input  1  imem accepts request
  imem_req_addr  output  XLEN  fetch address
  imem_rsp_valid  input  1  fetch data valid
  imem_rsp_data  input  32  fetched instruction
  if_valid  output  1  instruction valid toward decode
  if_ready  input  1  decode accepts instruction
  if_pc  output  XLEN  PC of presented instruction
  if_instr  output  32  presented instruction
  misalign_err  output  1  one-cycle pulse: redirect target not word-aligned

Function
REQ-003 States SHALL be REQ (request driven), WAIT (one request outstanding), OUT (instruction held for decode) and DROP (stale response pending); at most one request SHALL be outstanding.
REQ-004 REQ: imem_req_valid=1, imem_req_addr=pc; on valid&&ready -> WAIT; imem_rsp_valid ignored.
REQ-005 Without redirect, imem_req_addr SHALL stay stable while imem_req_valid=1 and ready=0.
REQ-006 WAIT: on imem_rsp_valid, capture imem_rsp_data into if_instr and pc into if_pc -> OUT; if_valid SHALL be 1 the cycle after the response (1-cycle latency).
REQ-007 OUT: if_valid, if_pc, if_instr held stable until if_valid&&if_ready; on that handshake pc <= pc+4 -> REQ, and if_valid=0 next cycle.
REQ-008 pc+4 SHALL wrap modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at XLEN=32).
REQ-009 redirect_valid SHALL take priority over all other events in every state: pc <= {redirect_pc[XLEN-1:2],2'b00}, and if_valid=0 next cycle.
REQ-010 Next state on redirect:
  - REQ without acceptance -> REQ, new address next cycle (sole exception to REQ-005).
  - REQ with same-cycle acceptance -> DROP.
  - WAIT without rsp_valid -> DROP.
  - WAIT with same-cycle rsp_valid -> REQ; response discarded.
  - OUT -> REQ; held instruction discarded, even if if_ready=1 that cycle.
  - DROP -> DROP; pc updated.
REQ-011 DROP: imem_req_valid=0; on imem_rsp_valid discard data -> REQ.
REQ-012 misalign_err SHALL pulse 1 the cycle after a redirect with redirect_pc[1:0]!=0, else 0.
REQ-013 imem_req_valid SHALL be 0 in WAIT, OUT and DROP.

Reset
REQ-014 On rst=1 at a clock edge: state=REQ, pc=RESET_VECTOR, if_valid=0, if_pc=0, if_instr=0, misalign_err=0; all in-flight activity abandoned, regardless of state.
REQ-015 First cycle after rst deasserts: imem_req_valid=1, imem_req_addr=RESET_VECTOR.
REQ-016 The imem SHALL be reset by the same rst; any imem_rsp_valid arriving in REQ SHALL be ignored.

Verification
REQ-017 Reset, then imem_req_ready=1, response 2 cycles later with data 0x00000013, if_ready=1 -> addr 0x0, if_pc=0x0, if_instr=0x00000013; next request addr 0x4.
REQ-018 if_ready=0 for 5 cycles in OUT -> if_valid/if_pc/if_instr unchanged, imem_req_valid=0; if_ready=1 -> next addr = if_pc+4.
REQ-019 Redirect to 0x100 in WAIT, response next cycle with data 0xDEADBEEF -> data never presented; next request addr 0x100.
REQ-020 Redirect to 0x203 -> misalign_err pulses one cycle; next request addr 0x200.
REQ-021 PC 0xFFFFFFFC fetched and accepted by decode -> next request addr 0x00000000.
REQ-022 rst asserted in OUT with if_valid=1 -> next cycle if_valid=0, following cycle request addr RESET_VECTOR.
